// File: rtl/mem_pkg.sv
// Shared load/store definitions: access size codes, unit FSM states and the
// bytes-per-access helper.
package mem_pkg;

    localparam int unsigned NB_BYTE  = 8;
    localparam int unsigned NB_COUNT = 3;

    // Size codes shared with the data memory addressing scheme
    localparam logic [1:0] SIZE_WORD = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_BYTE = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACCESS = 2'b01,
        ST_DONE   = 2'b10
    } state_t;

    function automatic logic [NB_COUNT-1:0] byte_count(input logic [1:0] size);
        logic [NB_COUNT-1:0] n;
        case (size)
            SIZE_WORD: n = 3'd4;
            SIZE_HALF: n = 3'd2;
            default:   n = 3'd1;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/mem_access_unit_load_extender.sv
// Sign/zero extension of an assembled load word; also used by writeback.
module load_extender
    import mem_pkg::*;
(
    input  logic [31:0] data,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    output logic [31:0] ext_data_c
);

    always_comb begin
        ext_data_c = data;
        case (size)
            SIZE_BYTE: ext_data_c = {{24{~is_unsigned & data[7]}}, data[7:0]};
            SIZE_HALF: ext_data_c = {{16{~is_unsigned & data[15]}}, data[15:0]};
            default:   ext_data_c = data;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store initiator: serialises word/half/byte requests into little-endian
// single-byte memory accesses and reassembles loads.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int unsigned NB_DATA    = 32,
    parameter int unsigned N_ADDRESS  = 64,
    parameter int unsigned NB_ADDRESS = $clog2(N_ADDRESS)
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_req_valid,
    output logic                  o_req_ready,
    input  logic                  i_req_we,
    input  logic [1:0]            i_req_size,
    input  logic                  i_req_unsigned,
    input  logic [NB_ADDRESS-1:0] i_req_addr,
    input  logic [NB_DATA-1:0]    i_req_wdata,
    output logic                  o_rsp_valid,
    output logic [NB_DATA-1:0]    o_rsp_rdata,
    output logic                  o_rsp_err,
    output logic [NB_ADDRESS-1:0] o_mem_addr,
    output logic                  o_mem_r_en,
    output logic                  o_mem_w_en,
    output logic [NB_BYTE-1:0]    o_mem_w_data,
    input  logic [NB_BYTE-1:0]    i_mem_r_data
);

    localparam int unsigned NB_SUM = NB_ADDRESS + 1;

    state_t                state_q, state_d;
    logic [1:0]            k_q, k_d;
    logic                  we_q, we_d;
    logic [1:0]            size_q, size_d;
    logic                  uns_q, uns_d;
    logic [NB_ADDRESS-1:0] addr_q, addr_d;
    logic [NB_DATA-1:0]    wdata_q, wdata_d;
    logic [NB_DATA-1:0]    asm_q, asm_d;
    logic                  err_q, err_d;

    logic                  req_ready_d, rsp_valid_d, rsp_err_d;
    logic [NB_DATA-1:0]    rsp_rdata_d;
    logic [NB_ADDRESS-1:0] mem_addr_d;
    logic                  mem_r_en_d, mem_w_en_d;
    logic [NB_BYTE-1:0]    mem_w_data_d;
    logic [NB_SUM-1:0]     addr_sum;
    logic [NB_DATA-1:0]    ext_c;

    load_extender u_load_extender (
        .data        (asm_d),
        .size        (size_d),
        .is_unsigned (uns_d),
        .ext_data_c  (ext_c)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Next state, request latching and load assembly; outputs are then
    // decoded from the next-state view so they can be registered.
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        we_d    = we_q;
        size_d  = size_q;
        uns_d   = uns_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        asm_d   = asm_q;
        err_d   = err_q;

        case (state_q)
            ST_IDLE: begin
                if (i_req_valid) begin
                    we_d    = i_req_we;
                    size_d  = i_req_size;
                    uns_d   = i_req_unsigned;
                    addr_d  = i_req_addr;
                    wdata_d = i_req_wdata;
                    asm_d   = '0;
                    k_d     = '0;
                    err_d   = (i_req_size == 2'b10)
                           || (i_req_size == SIZE_WORD && i_req_addr[1:0] != 2'b00)
                           || (i_req_size == SIZE_HALF && i_req_addr[0]);
                    state_d = err_d ? ST_DONE : ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (!we_q) asm_d[{k_q, 3'b000} +: NB_BYTE] = i_mem_r_data;
                if (NB_COUNT'(k_q) == byte_count(size_q) - 3'd1) state_d = ST_DONE;
                else                                              k_d = k_q + 2'd1;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        addr_sum = NB_SUM'(addr_d) + NB_SUM'(k_d);
        if (addr_sum >= NB_SUM'(N_ADDRESS)) addr_sum = addr_sum - NB_SUM'(N_ADDRESS);

        req_ready_d  = (state_d == ST_IDLE);
        mem_r_en_d   = (state_d == ST_ACCESS) && !we_d;
        mem_w_en_d   = (state_d == ST_ACCESS) && we_d;
        mem_addr_d   = (state_d == ST_ACCESS) ? addr_sum[NB_ADDRESS-1:0] : '0;
        mem_w_data_d = mem_w_en_d ? wdata_d[{k_d, 3'b000} +: NB_BYTE] : '0;
        rsp_valid_d  = (state_d == ST_DONE);
        rsp_err_d    = (state_d == ST_DONE) && err_d;
        rsp_rdata_d  = ((state_d == ST_DONE) && !err_d && !we_d) ? ext_c : '0;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            k_q          <= '0;
            we_q         <= 1'b0;
            size_q       <= SIZE_WORD;
            uns_q        <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            asm_q        <= '0;
            err_q        <= 1'b0;
            o_req_ready  <= 1'b1;
            o_rsp_valid  <= 1'b0;
            o_rsp_err    <= 1'b0;
            o_rsp_rdata  <= '0;
            o_mem_addr   <= '0;
            o_mem_r_en   <= 1'b0;
            o_mem_w_en   <= 1'b0;
            o_mem_w_data <= '0;
        end else begin
            k_q          <= k_d;
            we_q         <= we_d;
            size_q       <= size_d;
            uns_q        <= uns_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            asm_q        <= asm_d;
            err_q        <= err_d;
            o_req_ready  <= req_ready_d;
            o_rsp_valid  <= rsp_valid_d;
            o_rsp_err    <= rsp_err_d;
            o_rsp_rdata  <= rsp_rdata_d;
            o_mem_addr   <= mem_addr_d;
            o_mem_r_en   <= mem_r_en_d;
            o_mem_w_en   <= mem_w_en_d;
            o_mem_w_data <= mem_w_data_d;
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a byte-wide memory model.
module tb_mem_access_unit;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_req_valid;
    logic        o_req_ready;
    logic        i_req_we;
    logic [1:0]  i_req_size;
    logic        i_req_unsigned;
    logic [5:0]  i_req_addr;
    logic [31:0] i_req_wdata;
    logic        o_rsp_valid;
    logic [31:0] o_rsp_rdata;
    logic        o_rsp_err;
    logic [5:0]  o_mem_addr;
    logic        o_mem_r_en;
    logic        o_mem_w_en;
    logic [7:0]  o_mem_w_data;
    logic [7:0]  i_mem_r_data;

    logic [7:0]  mem [0:63];
    int          w_cnt, r_cnt, both_cnt, rsp_cnt, acc_cnt;
    logic [5:0]  w_addr_log [0:7];
    logic [7:0]  w_data_log [0:7];
    int          n_checks = 0;
    int          n_pass   = 0;

    logic [31:0] rd;
    logic        er;
    int          lat;

    mem_access_unit #(.NB_DATA(32), .N_ADDRESS(64), .NB_ADDRESS(6)) dut (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .i_req_valid    (i_req_valid),
        .o_req_ready    (o_req_ready),
        .i_req_we       (i_req_we),
        .i_req_size     (i_req_size),
        .i_req_unsigned (i_req_unsigned),
        .i_req_addr     (i_req_addr),
        .i_req_wdata    (i_req_wdata),
        .o_rsp_valid    (o_rsp_valid),
        .o_rsp_rdata    (o_rsp_rdata),
        .o_rsp_err      (o_rsp_err),
        .o_mem_addr     (o_mem_addr),
        .o_mem_r_en     (o_mem_r_en),
        .o_mem_w_en     (o_mem_w_en),
        .o_mem_w_data   (o_mem_w_data),
        .i_mem_r_data   (i_mem_r_data)
    );

    always #5 i_clk = ~i_clk;

    assign i_mem_r_data = mem[o_mem_addr];

    always @(posedge i_clk) begin
        if (o_mem_w_en) begin
            mem[o_mem_addr] = o_mem_w_data;
            if (w_cnt < 8) begin
                w_addr_log[w_cnt] = o_mem_addr;
                w_data_log[w_cnt] = o_mem_w_data;
            end
            w_cnt = w_cnt + 1;
        end
        if (o_mem_r_en) r_cnt = r_cnt + 1;
        if (o_mem_r_en && o_mem_w_en) both_cnt = both_cnt + 1;
        if (o_rsp_valid) rsp_cnt = rsp_cnt + 1;
        if (o_req_ready && i_req_valid && !i_rst) acc_cnt = acc_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (got === exp) n_pass = n_pass + 1;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic set_req(input logic we, input logic [1:0] size, input logic uns,
                           input logic [5:0] addr, input logic [31:0] wdata);
        i_req_we       = we;
        i_req_size     = size;
        i_req_unsigned = uns;
        i_req_addr     = addr;
        i_req_wdata    = wdata;
    endtask

    // Issues one request, returns response fields and acceptance-to-response latency
    task automatic run_req(input logic we, input logic [1:0] size, input logic uns,
                           input logic [5:0] addr, input logic [31:0] wdata,
                           output logic [31:0] rdata, output logic err, output int latency);
        int guard;
        @(negedge i_clk);
        set_req(we, size, uns, addr, wdata);
        i_req_valid = 1'b1;
        guard = 0;
        while (!o_req_ready && guard < 20) begin
            @(negedge i_clk);
            guard++;
        end
        w_cnt = 0;
        r_cnt = 0;
        latency = 0;
        do begin
            @(negedge i_clk);
            latency++;
            i_req_valid = 1'b0;
        end while (!o_rsp_valid && latency < 12);
        rdata = o_rsp_rdata;
        err   = o_rsp_err;
        @(negedge i_clk);
        check("rsp_one_cycle", 32'(o_rsp_valid), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 8'h00;
        w_cnt = 0; r_cnt = 0; both_cnt = 0; rsp_cnt = 0; acc_cnt = 0;
        i_rst = 1'b1;
        i_req_valid = 1'b0;
        set_req(1'b0, 2'b00, 1'b0, 6'h00, 32'h0);
        repeat (2) @(negedge i_clk);
        check("reset_ready", 32'(o_req_ready), 32'd1);
        check("reset_rsp_valid", 32'(o_rsp_valid), 32'd0);
        check("reset_enables", {30'd0, o_mem_r_en, o_mem_w_en}, 32'd0);
        i_rst = 1'b0;

        // 1: word store, little-endian byte order
        run_req(1'b1, 2'b00, 1'b0, 6'h08, 32'hDEADBEEF, rd, er, lat);
        check("st_word_lat", 32'(lat), 32'd5);
        check("st_word_err", 32'(er), 32'd0);
        check("st_word_rdata", rd, 32'd0);
        check("st_word_wcnt", 32'(w_cnt), 32'd4);
        check("st_word_rcnt", 32'(r_cnt), 32'd0);
        for (int i = 0; i < 4; i++) begin
            check("st_word_addr", 32'(w_addr_log[i]), 32'h08 + 32'(i));
        end
        check("st_word_b0", 32'(w_data_log[0]), 32'hEF);
        check("st_word_b1", 32'(w_data_log[1]), 32'hBE);
        check("st_word_b2", 32'(w_data_log[2]), 32'hAD);
        check("st_word_b3", 32'(w_data_log[3]), 32'hDE);

        // 2: half loads, signed and unsigned
        mem[6'h10] = 8'h80;
        mem[6'h11] = 8'hF1;
        run_req(1'b0, 2'b01, 1'b0, 6'h10, 32'h0, rd, er, lat);
        check("ld_half_s", rd, 32'hFFFFF180);
        check("ld_half_s_lat", 32'(lat), 32'd3);
        check("ld_half_s_rcnt", 32'(r_cnt), 32'd2);
        run_req(1'b0, 2'b01, 1'b1, 6'h10, 32'h0, rd, er, lat);
        check("ld_half_u", rd, 32'h0000F180);
        check("ld_half_u_err", 32'(er), 32'd0);

        // Word load passes through unextended
        mem[6'h12] = 8'h34;
        mem[6'h13] = 8'h92;
        run_req(1'b0, 2'b00, 1'b0, 6'h10, 32'h0, rd, er, lat);
        check("ld_word", rd, 32'h9234F180);
        check("ld_word_lat", 32'(lat), 32'd5);

        // 3: byte loads at the top address
        mem[6'h3F] = 8'h7F;
        run_req(1'b0, 2'b11, 1'b0, 6'h3F, 32'h0, rd, er, lat);
        check("ld_byte_pos", rd, 32'h0000007F);
        check("ld_byte_lat", 32'(lat), 32'd2);
        mem[6'h3F] = 8'h80;
        run_req(1'b0, 2'b11, 1'b0, 6'h3F, 32'h0, rd, er, lat);
        check("ld_byte_neg", rd, 32'hFFFFFF80);
        run_req(1'b0, 2'b11, 1'b1, 6'h3F, 32'h0, rd, er, lat);
        check("ld_byte_u", rd, 32'h00000080);

        // 4: errors, no memory traffic
        run_req(1'b0, 2'b00, 1'b0, 6'h06, 32'h0, rd, er, lat);
        check("err_word_err", 32'(er), 32'd1);
        check("err_word_lat", 32'(lat), 32'd1);
        check("err_word_rdata", rd, 32'd0);
        check("err_word_en", 32'(r_cnt + w_cnt), 32'd0);
        run_req(1'b1, 2'b01, 1'b0, 6'h03, 32'hFFFF_FFFF, rd, er, lat);
        check("err_half_err", 32'(er), 32'd1);
        check("err_half_lat", 32'(lat), 32'd1);
        check("err_half_en", 32'(r_cnt + w_cnt), 32'd0);
        check("err_half_mem", 32'(mem[6'h03]), 32'd0);
        run_req(1'b0, 2'b10, 1'b0, 6'h00, 32'h0, rd, er, lat);
        check("err_size_err", 32'(er), 32'd1);
        check("err_size_rdata", rd, 32'd0);
        check("err_size_en", 32'(r_cnt + w_cnt), 32'd0);

        // 5: back-to-back byte stores with valid held high
        @(negedge i_clk);
        acc_cnt = 0;
        w_cnt = 0;
        set_req(1'b1, 2'b11, 1'b0, 6'h30, 32'h0000_005A);
        i_req_valid = 1'b1;
        @(negedge i_clk);
        set_req(1'b1, 2'b11, 1'b0, 6'h31, 32'h0000_00A5);
        check("b2b_busy_ready", 32'(o_req_ready), 32'd0);
        @(negedge i_clk);
        check("b2b_first_rsp", 32'(o_rsp_valid), 32'd1);
        check("b2b_done_ready", 32'(o_req_ready), 32'd0);
        @(negedge i_clk);
        check("b2b_idle_ready", 32'(o_req_ready), 32'd1);
        check("b2b_acc_one", 32'(acc_cnt), 32'd1);
        @(negedge i_clk);
        i_req_valid = 1'b0;
        repeat (3) @(negedge i_clk);
        check("b2b_acc_two", 32'(acc_cnt), 32'd2);
        check("b2b_wcnt", 32'(w_cnt), 32'd2);
        check("b2b_mem30", 32'(mem[6'h30]), 32'h5A);
        check("b2b_mem31", 32'(mem[6'h31]), 32'hA5);

        // 6: reset during the third byte of a word store
        @(negedge i_clk);
        set_req(1'b1, 2'b00, 1'b0, 6'h20, 32'h1122_3344);
        i_req_valid = 1'b1;
        @(negedge i_clk);
        i_req_valid = 1'b0;
        @(negedge i_clk);
        rsp_cnt = 0;
        @(negedge i_clk);
        check("rst_mid_wen_before", 32'(o_mem_w_en), 32'd1);
        i_rst = 1'b1;
        #1;
        check("rst_mid_enables", {30'd0, o_mem_r_en, o_mem_w_en}, 32'd0);
        check("rst_mid_rsp", 32'(o_rsp_valid), 32'd0);
        @(negedge i_clk);
        i_rst = 1'b0;
        repeat (6) @(negedge i_clk);
        check("rst_no_rsp", 32'(rsp_cnt), 32'd0);
        check("rst_ready", 32'(o_req_ready), 32'd1);
        check("rst_mem20", 32'(mem[6'h20]), 32'h44);
        check("rst_mem21", 32'(mem[6'h21]), 32'h33);
        check("rst_mem22", 32'(mem[6'h22]), 32'h00);
        check("rst_mem23", 32'(mem[6'h23]), 32'h00);
        run_req(1'b0, 2'b11, 1'b1, 6'h21, 32'h0, rd, er, lat);
        check("post_rst_load", rd, 32'h00000033);

        check("never_both_en", 32'(both_cnt), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
Load/store initiator for the byte-wide data memory; sits between the MEM pipeline stage and the memory's read/write ports.
- Accepts one word/half/byte request at a time.
- Serialises the request into single-byte memory accesses in little-endian order.
- Reassembles loads with sign or zero extension.
- Flags misaligned requests without touching memory.

Parameters:
NB_DATA, 32, pipeline data width (fixed at 32; 4 bytes)
N_ADDRESS, 64, memory depth in bytes; must be a multiple of 4
NB_ADDRESS, $clog2(N_ADDRESS), byte address width

Ports:
i_clk  in  1  clock, rising edge
i_rst  in  1  reset, asynchronous, active-high
i_req_valid  in  1  request present
o_req_ready  out  1  unit can accept a request (high only in IDLE)
i_req_we  in  1  1=store, 0=load
i_req_size  in  2  00=word, 01=half, 11=byte, 10=invalid
i_req_unsigned  in  1  load: 1=zero-extend, 0=sign-extend
i_req_addr  in  NB_ADDRESS  byte address
i_req_wdata  in  NB_DATA  store data (low bytes used for half/byte)
o_rsp_valid  out  1  one-cycle completion pulse
o_rsp_rdata  out  NB_DATA  extended load data; 0 for stores and errors
o_rsp_err  out  1  misaligned or invalid size; qualified by o_rsp_valid
o_mem_addr  out  NB_ADDRESS  byte address to memory
o_mem_r_en  out  1  memory read enable
o_mem_w_en  out  1  memory write enable
o_mem_w_data  out  8  byte to write
i_mem_r_data  in  8  byte read, combinational from o_mem_addr

Behaviour:
Reset (async, i_rst=1):
- State=IDLE; all outputs 0 except o_req_ready=1.
- Memory enables drop immediately.
- An in-flight access is abandoned. No response is produced; partial stores stay partially written.

FSM states: IDLE, ACCESS, DONE.

IDLE:
- o_req_ready=1.
- On i_req_valid at a clock edge, latch we, size, unsigned, addr and wdata.
- Byte count n: word=4, half=2, byte=1.
- Error when: size=10; word with addr[1:0]!=00; half with addr[0]!=0.
- Error -> DONE with err latched. No memory enable is asserted.
- Otherwise -> ACCESS with byte counter k=0.

ACCESS:
- o_mem_addr = latched addr + k, modulo N_ADDRESS.
- Store: o_mem_w_en=1, o_mem_w_data = wdata byte k.
- Load: o_mem_r_en=1; i_mem_r_data is captured into byte k of the assembly register at the clock edge.
- Exactly one enable is high per cycle. k increments each cycle.
- After byte n-1 -> DONE.

DONE:
- o_rsp_valid=1 for exactly one cycle; o_rsp_err as latched.
- Load, no error: o_rsp_rdata = assembled value extended from bit 7 (byte) or bit 15 (half) per unsigned; word passes through unchanged.
- Store or error: o_rsp_rdata=0.
- Next state is IDLE. o_req_ready=0 in DONE.

Latency from acceptance edge to the o_rsp_valid cycle:
- word: 5 cycles
- half: 3 cycles
- byte: 2 cycles
- error: 1 cycle

Handshake and boundary rules:
- i_req_valid outside IDLE is ignored; the requester must hold it until ready.
- Request inputs are don't-care after acceptance.
- Memory outputs are registered from state/counter, not combinational from i_req_*.
- Aligned accesses never wrap because N_ADDRESS is a multiple of 4. The address adder still wraps modulo N_ADDRESS.

Decomposition:
Shared package (mem_pkg) holds:
- size codes WORD=2'b00, HALF=2'b01, BYTE=2'b11; these match the memory's addressing codes.
- FSM state encodings.
- A byte-count function.

Sub-module load_extender (combinational):
- Inputs: 32-bit assembled data, size, unsigned.
- Output: extended word.
- Reused by the writeback stage.

Test Plan:
1. Reset, then store word 0xDEADBEEF at 0x08. Response:
   - 4 consecutive o_mem_w_en cycles at addr 08..0B with data EF, BE, AD, DE.
   - o_rsp_valid 5 cycles after accept; err=0, rdata=0.
2. Memory bytes [0x10..0x11]=0x80,0xF1. Load half, signed, at 0x10 -> rdata=0xFFFFF180. Same load, unsigned -> 0x0000F180. Latency 3 cycles.
3. Memory [0x3F]=0x7F. Load byte, signed, at 0x3F -> rdata=0x0000007F. Then byte 0x80 signed -> 0xFFFFFF80.
4. Misaligned cases -> o_rsp_valid 1 cycle after accept with err=1, rdata=0, and no memory enable in any cycle:
   - load word at 0x06
   - store half at 0x03
   - size=10 at 0x00
5. Back-to-back requests with i_req_valid held high -> second request accepted only in the IDLE cycle after DONE; no request is lost or duplicated.
6. Assert i_rst during the third ACCESS cycle of a word store to 0x20. Response:
   - Enables drop in the same cycle; no o_rsp_valid.
   - Bytes 0x20..0x21 written, 0x22..0x23 untouched.
   - Unit ready after reset release.
